// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit, purchase, refund/change dispensing.
// Optional per-product stock counters are compiled in with VM_STOCK_EN.
module vending_machine_multi #(
    parameter int                              NUM_PRODUCTS = 4,
    parameter int                              CREDIT_W     = 10,
    parameter int                              MAX_CREDIT   = 500,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES      = {10'd100, 10'd70, 10'd50, 10'd30},
    parameter logic [7:0]                      STOCK_INIT   = 8'd8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          coin_in,
    input  logic [2:0]          button_in,
    input  logic                cancel,
    input  logic                restock,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          beverage_out,
    output logic [CREDIT_W-1:0] change_out,
    output logic                coin_reject,
    output logic                deny,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_t st_q, st_d;
    logic [CREDIT_W-1:0] credit_d, change_d;
    logic [2:0]          bev_d;
    logic                reject_d, deny_d;

    logic [NUM_PRODUCTS-1:0][CREDIT_W-1:0] price_tbl;
    logic [NUM_PRODUCTS-1:0]               stock_avail;
    logic [CREDIT_W-1:0]                   price_sel;
    logic                                  in_range, stock_ok;
    logic                                  coin_valid, coin_fits, cancel_go, buy_ok, buy;
    logic [CREDIT_W:0]                     coin_sum;

    assign price_tbl = PRICES;

    // Largest coin not exceeding the remaining credit; credit is always a multiple of 10.
    function automatic logic [CREDIT_W-1:0] change_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(200))      change_coin = CREDIT_W'(200);
        else if (c >= CREDIT_W'(100)) change_coin = CREDIT_W'(100);
        else if (c >= CREDIT_W'(50))  change_coin = CREDIT_W'(50);
        else if (c >= CREDIT_W'(20))  change_coin = CREDIT_W'(20);
        else if (c >= CREDIT_W'(10))  change_coin = CREDIT_W'(10);
        else                          change_coin = '0;
    endfunction

    always_comb begin
        price_sel = '0;
        in_range  = 1'b0;
        stock_ok  = 1'b0;
        for (int k = 0; k < NUM_PRODUCTS; k++) begin
            if (button_in == 3'(k+1)) begin
                in_range  = 1'b1;
                price_sel = price_tbl[k];
                stock_ok  = stock_avail[k];
            end
        end
    end

    assign coin_valid = (coin_in == 8'd10) || (coin_in == 8'd20) || (coin_in == 8'd50) ||
                        (coin_in == 8'd100) || (coin_in == 8'd200);
    assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_in);
    assign coin_fits  = coin_sum <= MAX_C;
    // Cancel with no credit does nothing, so it must not mask a coin or button.
    assign cancel_go  = cancel && (credit != '0);
    assign buy_ok     = in_range && (credit >= price_sel) && stock_ok;
    assign buy        = (st_q == IDLE) && !cancel_go && (coin_in == 8'd0) && buy_ok;

`ifdef VM_STOCK_EN
    logic [NUM_PRODUCTS-1:0][7:0] stock_q;

    always_comb begin
        stock_avail = '0;
        for (int k = 0; k < NUM_PRODUCTS; k++) stock_avail[k] = (stock_q[k] != 8'd0);
    end

    // Restock wins over a same-cycle purchase decrement.
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            for (int k = 0; k < NUM_PRODUCTS; k++) stock_q[k] <= STOCK_INIT;
        end else if (buy) begin
            for (int k = 0; k < NUM_PRODUCTS; k++)
                if (button_in == 3'(k+1)) stock_q[k] <= stock_q[k] - 8'd1;
        end
    end
`else
    logic unused_restock;
    assign unused_restock = restock;
    assign stock_avail    = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: begin
                if (cancel_go)             st_d = CHANGE;
                else if (coin_in != 8'd0)  st_d = IDLE;
                else if (buy_ok)           st_d = DELIVER;
            end
            DELIVER: st_d = (credit != '0) ? CHANGE : IDLE;
            CHANGE:  st_d = (credit == '0) ? IDLE : CHANGE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit;
        bev_d    = 3'd0;
        change_d = '0;
        reject_d = (coin_in != 8'd0);
        deny_d   = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (cancel_go) begin
                    reject_d = 1'b0;
                end else if (coin_in != 8'd0) begin
                    if (coin_valid && coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        reject_d = 1'b0;
                    end
                end else if (button_in != 3'd0) begin
                    if (buy_ok) begin
                        credit_d = credit - price_sel;
                        bev_d    = button_in;
                    end else begin
                        deny_d   = 1'b1;
                    end
                end
            end
            CHANGE: begin
                change_d = change_coin(credit);
                credit_d = credit - change_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit       <= '0;
            beverage_out <= 3'd0;
            change_out   <= '0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
        end else begin
            credit       <= credit_d;
            beverage_out <= bev_d;
            change_out   <= change_d;
            coin_reject  <= reject_d;
            deny         <= deny_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed vector table, hand sequences, and
// randomized traffic checked against a coin-queue reference model.
module tb_vending_machine_multi;

`ifdef VM_STOCK_EN
    localparam logic [7:0] TB_STOCK = 8'd1;
    localparam bit         STOCK_EN = 1'b1;
`else
    localparam logic [7:0] TB_STOCK = 8'd8;
    localparam bit         STOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] coin_in = 8'd0;
    logic [2:0] button_in = 3'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [9:0] credit;
    logic [2:0] beverage_out;
    logic [9:0] change_out;
    logic       coin_reject;
    logic       deny;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    vending_machine_multi #(.STOCK_INIT(TB_STOCK)) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .button_in(button_in),
        .cancel(cancel), .restock(restock), .credit(credit),
        .beverage_out(beverage_out), .change_out(change_out),
        .coin_reject(coin_reject), .deny(deny), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] coin;
        logic [2:0] btn;
        logic       can;
        logic       rs;
        int         cr, bev, chg, rej, dn, st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input int coin, input int btn, input logic can,
                               input logic rs, input int cr, input int bev, input int chg,
                               input int rej, input int dn, input int st);
        vec_t t;
        t.r = r; t.coin = 8'(coin); t.btn = 3'(btn); t.can = can; t.rs = rs;
        t.cr = cr; t.bev = bev; t.chg = chg; t.rej = rej; t.dn = dn; t.st = st;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample the registered response after the edge.
    task automatic step(input string tag, input logic r, input int coin, input int btn,
                        input logic can, input logic rs, input int cr, input int bev,
                        input int chg, input int rej, input int dn, input int st);
        rst = r; coin_in = 8'(coin); button_in = 3'(btn); cancel = can; restock = rs;
        @(posedge clk);
        #1;
        chk({tag, " credit"}, int'(credit), cr);
        chk({tag, " beverage_out"}, int'(beverage_out), bev);
        chk({tag, " change_out"}, int'(change_out), chg);
        chk({tag, " coin_reject"}, int'(coin_reject), rej);
        chk({tag, " deny"}, int'(deny), dn);
        chk({tag, " state"}, int'(state), st);
    endtask

    // Reference model: CHANGE is a queue of coins produced greedily from the credit.
    int m_credit, m_mode;
    int m_q[$];
    int m_stock[8];
    int e_bev, e_chg, e_rej, e_dn;
    int price[8] = '{0, 30, 50, 70, 100, 0, 0, 0};

    function automatic void greedy(input int c);
        int coins[5] = '{200, 100, 50, 20, 10};
        m_q.delete();
        while (c > 0) begin
            foreach (coins[i]) if (coins[i] <= c) begin
                m_q.push_back(coins[i]);
                c -= coins[i];
                break;
            end
        end
    endfunction

    function automatic void model(input logic r, input int coin, input int btn,
                                  input logic can, input logic rs);
        bit valid = (coin == 10) || (coin == 20) || (coin == 50) || (coin == 100) || (coin == 200);
        e_bev = 0; e_chg = 0; e_dn = 0; e_rej = (coin != 0);
        if (r) begin
            m_credit = 0; m_mode = 0; m_q.delete(); e_rej = 0;
            for (int k = 1; k <= 4; k++) m_stock[k] = int'(TB_STOCK);
            return;
        end
        case (m_mode)
            0: begin
                if (can && m_credit > 0) begin
                    e_rej = 0; m_mode = 2; greedy(m_credit);
                end else if (coin != 0) begin
                    if (valid && m_credit + coin <= 500) begin
                        m_credit += coin; e_rej = 0;
                    end
                end else if (btn != 0) begin
                    if (btn <= 4 && m_credit >= price[btn] && (!STOCK_EN || m_stock[btn] > 0)) begin
                        m_credit -= price[btn]; e_bev = btn; m_mode = 1; m_stock[btn]--;
                    end else e_dn = 1;
                end
            end
            1: begin
                m_mode = (m_credit > 0) ? 2 : 0;
                if (m_mode == 2) greedy(m_credit);
            end
            default: begin
                if (m_q.size() > 0) begin
                    e_chg = m_q.pop_front(); m_credit -= e_chg;
                end else m_mode = 0;
            end
        endcase
        if (rs) for (int k = 1; k <= 4; k++) m_stock[k] = int'(TB_STOCK);
    endfunction

    initial begin
        int coin_pool[11] = '{0, 0, 0, 10, 20, 50, 100, 200, 25, 5, 255};

        //        rst coin btn can rs   cr bev chg rej dn st
        tbl.push_back(v(1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 50,  0, 0, 0,  50, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 20,  0, 0, 0,  70, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 0,   1, 0, 0,  40, 1,   0, 0, 0, 1));
        tbl.push_back(v(0, 0,   0, 0, 0,  40, 0,   0, 0, 0, 2));
        tbl.push_back(v(0, 10,  0, 0, 0,  20, 0,  20, 1, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,  20, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 25,  0, 0, 0,   0, 0,   0, 1, 0, 0));
        tbl.push_back(v(0, 20,  0, 0, 0,  20, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 20,  0, 0, 0,  40, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 0,   2, 0, 0,  40, 0,   0, 0, 1, 0));
        tbl.push_back(v(0, 0,   5, 0, 0,  40, 0,   0, 0, 1, 0));
        tbl.push_back(v(0, 200, 0, 0, 0, 240, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 200, 0, 0, 0, 440, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 10,  0, 0, 0, 450, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 100, 0, 0, 0, 450, 0,   0, 1, 0, 0));
        tbl.push_back(v(0, 50,  0, 1, 0, 450, 0,   0, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0, 250, 0, 200, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,  50, 0, 200, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,  50, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 50,  1, 0, 0,  50, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 10,  0, 0, 0,  60, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 0,   1, 0, 0,  30, 1,   0, 0, 0, 1));
        tbl.push_back(v(0, 0,   1, 0, 0,  30, 0,   0, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 1, 0,  10, 0,  20, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,  10, 0, 0, 2));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 200, 0, 0, 0, 200, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 100, 0, 0, 0, 300, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 0,   4, 0, 0, 200, 4,   0, 0, 0, 1));
        tbl.push_back(v(0, 0,   0, 0, 0, 200, 0,   0, 0, 0, 2));
        tbl.push_back(v(1, 50,  0, 1, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 50,  0, 0, 0,  50, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 0,   2, 0, 0,   0, 2,   0, 0, 0, 1));
        tbl.push_back(v(0, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 200, 0, 0, 0, 200, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 200, 0, 0, 0, 400, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 100, 0, 0, 0, 500, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 10,  0, 0, 0, 500, 0,   0, 1, 0, 0));
        tbl.push_back(v(1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].r, int'(tbl[i].coin), int'(tbl[i].btn),
                 tbl[i].can, tbl[i].rs, tbl[i].cr, tbl[i].bev, tbl[i].chg,
                 tbl[i].rej, tbl[i].dn, tbl[i].st);

        // Reset taken while a beverage is being delivered, with a coin in the same cycle.
        step("rdl0", 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("rdl1", 0, 50, 0, 0, 0, 50, 0, 0, 0, 0, 0);
        step("rdl2", 0, 0,  2, 0, 1,  0, 2, 0, 0, 0, 1);
        step("rdl3", 1, 50, 0, 0, 0,  0, 0, 0, 0, 0, 0);

`ifdef VM_STOCK_EN
        // Single-unit stock: second purchase of product 3 is denied until restock.
        step("stk0", 1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("stk1", 0, 50, 0, 0, 0, 50, 0, 0, 0, 0, 0);
        step("stk2", 0, 20, 0, 0, 0, 70, 0, 0, 0, 0, 0);
        step("stk3", 0, 0,  3, 0, 0,  0, 3, 0, 0, 0, 1);
        step("stk4", 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("stk5", 0, 50, 0, 0, 0, 50, 0, 0, 0, 0, 0);
        step("stk6", 0, 20, 0, 0, 0, 70, 0, 0, 0, 0, 0);
        step("stk7", 0, 0,  3, 0, 0, 70, 0, 0, 0, 1, 0);
        step("stk8", 0, 0,  0, 0, 1, 70, 0, 0, 0, 0, 0);
        step("stk9", 0, 0,  3, 0, 0,  0, 3, 0, 0, 0, 1);
        step("stkA", 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            logic r, can, rs;
            int coin, btn;
            r    = (n == 0) || ($urandom_range(0, 99) == 0);
            coin = coin_pool[$urandom_range(0, 10)];
            btn  = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 7)) : 0;
            can  = ($urandom_range(0, 11) == 0);
            rs   = ($urandom_range(0, 19) == 0);
            model(r, coin, btn, can, rs);
            step($sformatf("rnd%0d", n), r, coin, btn, can, rs,
                 m_credit, e_bev, e_chg, e_rej, e_dn, m_mode);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 Parameter NUM_PRODUCTS, 4: product count, 1..7.
REQ-002 Parameter CREDIT_W, 10: credit and change width in bits.
REQ-003 Parameter MAX_CREDIT, 500: credit ceiling; must be below 2**CREDIT_W.
REQ-004 Parameter PRICES, {100,70,50,30}: packed NUM_PRODUCTS x CREDIT_W price table; product k uses slice k-1; each price is a nonzero multiple of 10.
REQ-005 Parameter STOCK_INIT, 8: per-product stock loaded on reset and on restock; 8-bit counters.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 coin_in  input  8  coin value this cycle; 0 = none.
REQ-009 button_in  input  3  product select; 0 = none, k = product k.
REQ-010 cancel  input  1  request refund of the whole credit.
REQ-011 restock  input  1  reload stock (only with VM_STOCK_EN).
REQ-012 credit  output  CREDIT_W  current credit, registered.
REQ-013 beverage_out  output  3  product number delivered, one-cycle pulse; 0 = none.
REQ-014 change_out  output  CREDIT_W  coin value returned this cycle; 0 = none.
REQ-015 coin_reject  output  1  one-cycle pulse; the coin from the previous cycle is returned.
REQ-016 deny  output  1  one-cycle pulse; the previous cycle's purchase was refused.
REQ-017 state  output  2  0 IDLE, 1 DELIVER, 2 CHANGE.

Function
REQ-018 All outputs are registered; every response appears on the cycle after the causing input.
REQ-019 Valid coins are 10, 20, 50, 100 and 200.
REQ-020 In IDLE, a valid coin with credit+coin <= MAX_CREDIT raises credit by the coin value on the next cycle.
REQ-021 Any other nonzero coin_in (invalid value, overflow, or arriving outside IDLE) leaves credit unchanged and pulses coin_reject.
REQ-022 IDLE priority is cancel > coin > button; a lower-priority request in the same cycle is ignored, with no deny and no reject.
REQ-023 A button k (1..NUM_PRODUCTS) in IDLE with credit >= price(k) and stock(k) > 0 moves to DELIVER; on that cycle beverage_out=k, credit drops by price(k), stock(k) drops by 1.
REQ-024 A button that fails the REQ-023 conditions, or k > NUM_PRODUCTS, pulses deny; beverage_out stays 0; credit and state are unchanged.
REQ-025 DELIVER lasts exactly one cycle, then goes to CHANGE if credit > 0, else to IDLE.
REQ-026 Cancel in IDLE with credit > 0 goes to CHANGE; cancel with credit = 0 is ignored.
REQ-027 In CHANGE, each cycle sets change_out to the largest valid coin <= credit and lowers credit by that amount in the same cycle; when credit reaches 0, return to IDLE on the next cycle.
REQ-028 change_out is 0 outside CHANGE; beverage_out is 0 outside DELIVER.
REQ-029 button_in and cancel are ignored in DELIVER and CHANGE.
REQ-030 Credit is always a multiple of 10 and never exceeds MAX_CREDIT.

Reset
REQ-031 rst, sampled at a clock edge, forces state IDLE, credit 0, and beverage_out, change_out, coin_reject and deny all 0 on the next cycle.
REQ-032 rst reloads every stock counter to STOCK_INIT.
REQ-033 rst overrides every other input in every state; credit is forfeited mid-CHANGE.

Configuration
REQ-034 Macro VM_STOCK_EN compiled in: per-product stock counters exist, sold-out buttons pulse deny, and restock reloads all counters to STOCK_INIT in any state; restock and a purchase in the same cycle give STOCK_INIT.
REQ-035 VM_STOCK_EN absent: no stock counters; stock is treated as unlimited and restock is ignored.

Verification
REQ-036 Coins 50 then 20 in IDLE -> credit 50, then 70; no coin_reject.
REQ-037 Credit 70, button 1 (price 30) -> next cycle beverage_out=1, credit 40, state DELIVER; then change_out 20, 20; credit 0; state IDLE.
REQ-038 Credit 40, button 2 (price 50) -> deny pulse; beverage_out 0; credit stays 40.
REQ-039 Credit 450, coin 100 -> coin_reject; credit 450; then cancel -> change_out 200, 200, 50; then IDLE.
REQ-040 coin_in 25 in IDLE, or coin 10 during CHANGE -> coin_reject; credit is unaffected except for the CHANGE decrement.
REQ-041 VM_STOCK_EN with STOCK_INIT=1: two paid purchases of product 3 -> the second pulses deny; restock, then a retry -> beverage_out=3.
